// File: rtl/types_pkg.sv
// Shared core types: word type, data-memory request/response records and
// the data-memory responder state encoding.
package types_pkg;

    localparam int unsigned XLEN = 32;

    typedef logic [XLEN-1:0] word_t;

    typedef struct packed {
        logic       write;
        word_t      addr;
        word_t      wdata;
        logic [3:0] be;
    } mem_req_t;

    typedef struct packed {
        word_t rdata;
        logic  err;
    } mem_resp_t;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StResp
    } dmem_state_t;

endpackage

// File: rtl/dmem_array.sv
// DEPTH x XLEN word storage: synchronous byte-enabled write, combinational read.
module dmem_array
    import types_pkg::*;
#(
    parameter int unsigned DEPTH  = 256,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  word_t             wdata_i,
    input  logic [3:0]        be_i,
    output word_t             rdata_o
);

    word_t mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int i = 0; i < 4; i++) begin
                if (be_i[i]) begin
                    mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
                end
            end
        end
    end

    assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: valid/ready request in, LATENCY wait states, commit on
// entry to the response state, valid/ready response out.
module dmem_responder
    import types_pkg::*;
#(
    parameter int unsigned DEPTH   = 256,
    parameter int unsigned LATENCY = 2,
    parameter int unsigned ADDR_W  = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_write,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    input  logic [3:0]      req_be,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_rdata,
    output logic            resp_err
);

    localparam logic [3:0] CntInit = 4'(LATENCY == 0 ? 0 : LATENCY - 1);

    dmem_state_t state_q;
    mem_req_t    req_q;
    mem_resp_t   resp_q;
    logic [3:0]  cnt_q;
    logic        req_ready_q;
    logic        resp_valid_q;

    logic        accept;
    logic        commit;
    logic        in_range;
    logic        mem_we;
    mem_req_t    cur_req;
    mem_resp_t   resp_d;
    word_t       mem_rdata;

    // With zero latency the commit happens on the accepting edge, so the live
    // request inputs feed the array instead of the captured copy.
    always_comb begin
        accept       = (state_q == StIdle) && req_valid && req_ready_q;
        cur_req      = (state_q == StIdle) ?
                       '{write: req_write, addr: req_addr, wdata: req_wdata, be: req_be} : req_q;
        commit       = (LATENCY == 0) ? accept : ((state_q == StWait) && (cnt_q == 4'd0));
        in_range     = cur_req.addr < XLEN'(DEPTH);
        mem_we       = commit && cur_req.write && in_range && !reset;
        resp_d.err   = !in_range;
        resp_d.rdata = (in_range && !cur_req.write) ? mem_rdata : '0;
    end

    dmem_array #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk_i   (clk),
        .we_i    (mem_we),
        .addr_i  (cur_req.addr[ADDR_W-1:0]),
        .wdata_i (cur_req.wdata),
        .be_i    (cur_req.be),
        .rdata_o (mem_rdata)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_q       <= '0;
            cnt_q        <= 4'd0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        req_q       <= cur_req;
                        req_ready_q <= 1'b0;
                        if (LATENCY == 0) begin
                            state_q      <= StResp;
                            resp_valid_q <= 1'b1;
                            resp_q       <= resp_d;
                        end else begin
                            state_q <= StWait;
                            cnt_q   <= CntInit;
                        end
                    end
                end
                StWait: begin
                    if (cnt_q == 4'd0) begin
                        state_q      <= StResp;
                        resp_valid_q <= 1'b1;
                        resp_q       <= resp_d;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                StResp: begin
                    if (resp_ready) begin
                        state_q      <= StIdle;
                        req_ready_q  <= 1'b1;
                        resp_valid_q <= 1'b0;
                        resp_q       <= '0;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_q.rdata;
    assign resp_err   = resp_q.err;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed table, reset/zero-latency sequences and
// randomized traffic against a word-array reference model.
module tb_dmem_responder;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_write, resp_valid, resp_ready, resp_err;
    logic [31:0] req_addr, req_wdata, resp_rdata;
    logic [3:0]  req_be;
    logic        b_req_valid, b_req_ready, b_req_write, b_resp_valid, b_resp_ready, b_resp_err;
    logic [31:0] b_req_addr, b_req_wdata, b_resp_rdata;
    logic [3:0]  b_req_be;

    int checks = 0;
    int errors = 0;

    logic [31:0] model [256];

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH(256), .LATENCY(LAT)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_be     (req_be),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err)
    );

    dmem_responder #(.DEPTH(256), .LATENCY(0)) dut0 (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (b_req_valid),
        .req_ready  (b_req_ready),
        .req_write  (b_req_write),
        .req_addr   (b_req_addr),
        .req_wdata  (b_req_wdata),
        .req_be     (b_req_be),
        .resp_valid (b_resp_valid),
        .resp_ready (b_resp_ready),
        .resp_rdata (b_resp_rdata),
        .resp_err   (b_resp_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: out-of-range is an error with no storage change; stores merge
    // enabled bytes and answer 0; loads return the whole word.
    task automatic model_apply(input logic w, input logic [31:0] a, input logic [31:0] wd,
                               input logic [3:0] be, output logic [31:0] rd, output logic er);
        if (a >= 32'd256) begin
            rd = '0;
            er = 1'b1;
        end else begin
            er = 1'b0;
            rd = '0;
            if (w) begin
                for (int i = 0; i < 4; i++) begin
                    if (be[i]) model[a][8*i +: 8] = wd[8*i +: 8];
                end
            end else begin
                rd = model[a];
            end
        end
    endtask

    task automatic txn(input string name, input logic w, input logic [31:0] a,
                       input logic [31:0] wd, input logic [3:0] be,
                       input logic [31:0] exp_rd, input logic exp_er, input int hold);
        int n;
        int lat;
        logic [31:0] rd0;
        logic er0;
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wdata = wd;
        req_be    = be;
        n = 0;
        while (!req_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk({name, " ready"}, 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_write = 1'($urandom);
        req_addr  = $urandom;
        req_wdata = $urandom;
        req_be    = 4'($urandom);
        lat = 1;
        while (!resp_valid && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({name, " latency"}, 32'(lat), 32'(LAT + 1));
        chk({name, " rdata"}, resp_rdata, exp_rd);
        chk({name, " err"}, 32'(resp_err), 32'(exp_er));
        rd0 = resp_rdata;
        er0 = resp_err;
        for (int i = 0; i < hold; i++) begin
            if (i == 1) begin
                req_valid = 1'b1;
                req_write = 1'b0;
                req_addr  = 32'd0;
            end
            @(posedge clk); #1;
            chk({name, " hold flags"}, 32'({resp_valid, req_ready, resp_err}),
                32'({1'b1, 1'b0, er0}));
            chk({name, " hold rdata"}, resp_rdata, rd0);
        end
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        chk({name, " done"}, 32'({resp_valid, req_ready, resp_err}), 32'b010);
        chk({name, " done rdata"}, resp_rdata, 32'd0);
    endtask

    typedef struct {
        logic        w;
        logic [31:0] a;
        logic [31:0] wd;
        logic [3:0]  be;
        logic [31:0] erd;
        logic        eer;
        int          hold;
    } vec_t;

    vec_t vecs [16];

    initial begin
        logic [31:0] rd;
        logic        er;
        int          acc;

        vecs[0]  = '{1'b1, 32'd5,   32'hDEADBEEF, 4'hF, 32'h0,        1'b0, 0};
        vecs[1]  = '{1'b0, 32'd5,   32'h0,        4'h0, 32'hDEADBEEF, 1'b0, 4};
        vecs[2]  = '{1'b1, 32'd7,   32'h11223344, 4'hF, 32'h0,        1'b0, 0};
        vecs[3]  = '{1'b1, 32'd7,   32'h000000AA, 4'h1, 32'h0,        1'b0, 0};
        vecs[4]  = '{1'b0, 32'd7,   32'h0,        4'h0, 32'h112233AA, 1'b0, 0};
        vecs[5]  = '{1'b0, 32'd300, 32'h0,        4'hF, 32'h0,        1'b1, 0};
        vecs[6]  = '{1'b1, 32'd44,  32'h44444444, 4'hF, 32'h0,        1'b0, 0};
        vecs[7]  = '{1'b1, 32'd300, 32'h12345678, 4'hF, 32'h0,        1'b1, 0};
        vecs[8]  = '{1'b0, 32'd44,  32'h0,        4'h0, 32'h44444444, 1'b0, 0};
        vecs[9]  = '{1'b1, 32'd9,   32'hCAFEF00D, 4'hF, 32'h0,        1'b0, 0};
        vecs[10] = '{1'b1, 32'd9,   32'hFFFFFFFF, 4'h0, 32'h0,        1'b0, 0};
        vecs[11] = '{1'b0, 32'd9,   32'h0,        4'h0, 32'hCAFEF00D, 1'b0, 0};
        vecs[12] = '{1'b1, 32'd9,   32'h00ABCD00, 4'h6, 32'h0,        1'b0, 0};
        vecs[13] = '{1'b0, 32'd9,   32'h0,        4'hF, 32'hCAABCD0D, 1'b0, 0};
        vecs[14] = '{1'b1, 32'd3,   32'h33333333, 4'hF, 32'h0,        1'b0, 0};
        vecs[15] = '{1'b0, 32'd3,   32'h0,        4'h0, 32'h33333333, 1'b0, 0};

        reset = 1'b1;
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0;
        resp_ready = 1'b0;
        b_req_valid = 1'b0; b_req_write = 1'b0; b_req_addr = '0; b_req_wdata = '0;
        b_req_be = '0; b_resp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset flags", 32'({req_ready, resp_valid, resp_err}), 32'b100);
        chk("reset rdata", resp_rdata, 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 16; i++) begin
            model_apply(vecs[i].w, vecs[i].a, vecs[i].wd, vecs[i].be, rd, er);
            txn($sformatf("vec%0d", i), vecs[i].w, vecs[i].a, vecs[i].wd, vecs[i].be,
                vecs[i].erd, vecs[i].eer, vecs[i].hold);
        end

        // Store to addr 3 abandoned by reset while waiting.
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'd3;
        req_wdata = 32'hBAD0BAD0; req_be = 4'hF;
        @(posedge clk); #1;
        req_valid = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        chk("rst wait flags", 32'({req_ready, resp_valid, resp_err}), 32'b100);
        chk("rst wait rdata", resp_rdata, 32'd0);
        @(posedge clk); #1;
        chk("rst hold flags", 32'({req_ready, resp_valid, resp_err}), 32'b100);
        reset = 1'b0;
        txn("rst load3", 1'b0, 32'd3, 32'h0, 4'h0, 32'h33333333, 1'b0, 0);

        for (int a = 0; a < 256; a++) begin
            logic [31:0] d;
            d = $urandom;
            model_apply(1'b1, 32'(a), d, 4'hF, rd, er);
            txn("fill", 1'b1, 32'(a), d, 4'hF, rd, er, 0);
        end
        for (int i = 0; i < 150; i++) begin
            logic        w;
            logic [31:0] a;
            logic [31:0] d;
            logic [3:0]  be;
            w  = 1'($urandom);
            a  = $urandom_range(0, 299);
            d  = $urandom;
            be = 4'($urandom);
            model_apply(w, a, d, be, rd, er);
            txn($sformatf("rnd%0d", i), w, a, d, be, rd, er, int'($urandom_range(0, 2)));
        end

        // Zero-latency build: response in the cycle after the handshake cycle.
        b_req_valid = 1'b1; b_req_write = 1'b1; b_req_addr = 32'd2;
        b_req_wdata = 32'h5A5A1234; b_req_be = 4'hF;
        @(posedge clk); #1;
        b_req_valid = 1'b0;
        chk("l0 store resp", 32'({b_resp_valid, b_req_ready, b_resp_err}), 32'b100);
        b_resp_ready = 1'b1;
        @(posedge clk); #1;
        chk("l0 store done", 32'({b_resp_valid, b_req_ready}), 32'b01);
        b_req_valid = 1'b1; b_req_write = 1'b0; b_req_addr = 32'd2;
        acc = 0;
        for (int i = 0; i < 10; i++) begin
            if (b_req_valid && b_req_ready) acc++;
            @(posedge clk); #1;
            if (i % 2 == 0) begin
                chk("l0 load resp", 32'({b_resp_valid, b_resp_err}), 32'b10);
                chk("l0 load rdata", b_resp_rdata, 32'h5A5A1234);
            end
        end
        chk("l0 accepts", 32'(acc), 32'd5);
        b_req_valid = 1'b0;
        b_resp_ready = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
Data-memory responder for the pipelined core's Memory stage. It accepts load/store requests through a valid/ready handshake, inserts a configurable number of wait states, and returns the response through a second valid/ready handshake. It replaces the zero-latency data memory, so the hazard unit can stall the pipeline on real memory latency. Addresses are word addresses, matching the core's word-indexed memories.

Parameters:
XLEN, 32, data and address width
DEPTH, 256, number of words of storage
LATENCY, 2, wait-state cycles between acceptance and commit; legal range 0..15
ADDR_W, $clog2(DEPTH), index width (derived; do not override)

Ports:
clk  in  1  clock; all state updates on the rising edge
reset  in  1  synchronous, active-high reset
req_valid  in  1  requester presents a request
req_ready  out  1  responder can accept a request
req_write  in  1  1 = store, 0 = load
req_addr  in  XLEN  word address
req_wdata  in  XLEN  store data
req_be  in  4  store byte enables; bit i covers bits [8i+7:8i]
resp_valid  out  1  response available
resp_ready  in  1  requester consumes the response
resp_rdata  out  XLEN  load data; 0 for stores and errors
resp_err  out  1  address is out of range (req_addr >= DEPTH)

Behaviour:
- One clock (clk). Reset is synchronous and active-high (reset).
- State machine states: IDLE, WAIT, RESP.
- Reset values: state = IDLE, req_ready = 1, resp_valid = 0, resp_rdata = 0, resp_err = 0, wait counter = 0. Storage contents are not reset.
- req_ready = 1 only in IDLE.
- Throughput is one transaction per LATENCY+2 cycles minimum. A new request is never accepted in the same cycle a response is consumed.
- IDLE:
  - On req_valid & req_ready, capture write, addr, wdata and be.
  - If LATENCY = 0, go to RESP.
  - Otherwise load counter = LATENCY-1 and go to WAIT.
- WAIT: decrement the counter each cycle. The transition to RESP happens in the cycle the counter is 0.
- Commit point is the edge entering RESP. At that edge:
  - Store, in range: write only the enabled bytes. resp_rdata = 0, resp_err = 0.
  - Load, in range: resp_rdata = full word at addr (req_be ignored), resp_err = 0.
  - Out of range: no storage change, resp_rdata = 0, resp_err = 1.
- Latency: a request accepted at edge T produces resp_valid = 1 from edge T+1+LATENCY.
- RESP:
  - resp_valid = 1. resp_rdata and resp_err are held stable until resp_valid & resp_ready.
  - On handshake, go to IDLE, clear resp_valid, resp_rdata and resp_err.
- Request inputs are ignored outside IDLE; the requester holds them only until accepted.
- req_be = 0 on a store: no bytes change, and a normal response is returned.
- Read-after-write: a load accepted after a store's response has been consumed returns the updated data. There is no overlap, so no bypass is needed.
- Reset in WAIT: the transaction is abandoned; a pending store is NOT committed. Reset in RESP: the response is dropped.
- Reset has priority over every other event in the same cycle.

Decomposition:
- Shared package (types_pkg):
  - XLEN and word_t (already shared)
  - mem_req_t struct {write, addr, wdata, be}
  - mem_resp_t struct {rdata, err}
  - dmem_state_t enum {IDLE, WAIT, RESP}
- Sub-module dmem_array: DEPTH x XLEN storage with a synchronous byte-enabled write and a combinational read. The FSM and handshakes live in dmem_responder.

Test Plan:
- Reset, then LATENCY = 2: store addr 5, data 0xDEADBEEF, be 0xF; then load addr 5 -> resp_valid 3 cycles after each acceptance, load resp_rdata = 0xDEADBEEF, resp_err = 0.
- Partial store: store 0x000000AA with be 0x1 over 0x11223344 at addr 7, then load -> 0x112233AA.
- Backpressure: hold resp_ready = 0 for 4 cycles on a load -> resp_valid and resp_rdata stable, req_ready = 0 throughout; a request offered meanwhile is not accepted.
- Load addr 300 with DEPTH = 256 -> resp_err = 1, resp_rdata = 0. Store to addr 300 -> resp_err = 1, and no word in storage changes.
- Reset asserted in the cycle after a store to addr 3 is accepted (LATENCY = 2), then load addr 3 -> returns the old contents; outputs show reset values during reset.
- LATENCY = 0 build: load accepted at edge T -> resp_valid from edge T+1; back-to-back load issued with resp_ready held at 1 -> accepted every 2 cycles.
